spio_hss_multiplexer_frame_sched: RTL and testbench
===================================================

Name: spio_hss_multiplexer_frame_sched

Overview:
Frame scheduler that sequences the per-channel packet stores of the HSS multiplexer. It allocates frame sequence numbers and issues a simultaneous bpkt_rq to all channel stores. It collects the grant mask, presents a frame descriptor to the frame issue stage, and limits outstanding (unacked) frames to a window. On nack it rewinds the sequence number; the stores rewind their read pointers in the same cycle.

Parameters:
NUM_CH, 8, number of packet stores (channels) served.
SEQ_BITS, 7, frame sequence number width; matches the common-header value.
WIN, 8, max unacked frames; must be <= BUF_LEN-1 of the stores and < 2^(SEQ_BITS-1).

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
st_empty  in  NUM_CH  per-store empty flag (no unread data)
bpkt_rq  out  NUM_CH  request to each store; all bits driven together
bpkt_seq  out  SEQ_BITS  sequence number for current request
bpkt_gt  in  NUM_CH  per-store grant, 1 cycle after bpkt_rq
vld_ack  in  1  remote ack valid
vld_nak  in  1  remote nack valid
ack_seq  in  SEQ_BITS  first un-acked (ack) / to-resend (nak) sequence
frm_vld  out  1  frame descriptor valid
frm_rdy  in  1  frame issue accepts descriptor
frm_mask  out  NUM_CH  channels contributing a packet
frm_seq  out  SEQ_BITS  sequence number of presented frame
win_full  out  1  window full (status)

Behaviour:
- Reset values: bpkt_rq=0, bpkt_seq=0, frm_vld=0, frm_mask=0, frm_seq=0, win_full=0, seq=0, ack_base=0, state=IDLE.
- Counters: seq (next seq to allocate), ack_base (oldest unacked). outstanding = (seq - ack_base) mod 2^SEQ_BITS. win_full = (outstanding >= WIN), combinational from registers.
- vld_ack or vld_nak: ack_base <= ack_seq. vld_nak additionally: seq <= ack_seq. If both are asserted, nak takes priority (same ack_seq).
- FSM states IDLE, REQ, COLLECT, ISSUE.
- IDLE: go to REQ when |(~st_empty) && !win_full && !vld_nak; otherwise stay.
- REQ (1 cycle): bpkt_rq = all ones, bpkt_seq = seq. Next state COLLECT. A vld_nak in this cycle goes to IDLE. The request is still seen by the stores; nak priority in the stores discards it.
- COLLECT (1 cycle): mask = bpkt_gt.
  - vld_nak this cycle: discard mask, seq <= ack_seq, go to IDLE.
  - mask==0 (remote cfc off on all channels): no frame, seq unchanged, go to IDLE.
  - else: frm_vld <= 1, frm_mask <= mask, frm_seq <= seq, seq <= seq+1 (wraps mod 2^SEQ_BITS), go to ISSUE.
- ISSUE: frm_vld, frm_mask and frm_seq stay stable until frm_vld && frm_rdy. On the handshake cycle frm_vld <= 0 and the FSM goes to IDLE.
  - A nak while in ISSUE still updates seq and ack_base; the pending descriptor is completed unchanged.
- Minimum frame period: 4 cycles (IDLE, REQ, COLLECT, ISSUE with frm_rdy=1).
- bpkt_rq is asserted only in REQ, so each store's seq map is written once per allocated sequence.
- Window boundary: with outstanding == WIN-1, one more frame may be issued; afterwards the FSM stays in IDLE until an ack reduces outstanding.
- Wrap-around: all sequence comparisons use modular SEQ_BITS subtraction. An ack_seq outside [ack_base, seq] is a protocol error and is not checked.
- Reset mid-frame: all state returns to reset values immediately (async). The frame issue stage must ignore a truncated handshake.

Decomposition:
- Shared package/header: SEQ_BITS, NUM_CH, WIN, and the FSM state encoding constants (IDLE=2'd0, REQ=2'd1, COLLECT=2'd2, ISSUE=2'd3).
- One natural sub-module, spio_hss_multiplexer_seq_window: holds seq and ack_base, applies the ack/nak/increment rules, and outputs seq, outstanding and win_full.
- The FSM and descriptor registers stay in the top module.

Test Plan:
- Store 3 non-empty, bpkt_gt=8'h08 returned; frm_rdy=1 -> bpkt_rq=8'hFF for 1 cycle with bpkt_seq=0; frm_vld with frm_mask=8'h08, frm_seq=0; seq becomes 1; 4-cycle period.
- All stores non-empty, bpkt_gt=0 -> no frm_vld, seq stays 0, FSM retries from IDLE.
- Issue 8 frames with no acks (WIN=8) -> win_full=1, no further bpkt_rq. vld_ack with ack_seq=3 -> win_full=0, the next request uses bpkt_seq=8.
- After frames 0..5, vld_nak with ack_seq=2 asserted during COLLECT -> mask discarded, no frm_vld; next bpkt_seq=2, ack_base=2.
- frm_rdy held low for 10 cycles -> frm_vld, frm_mask and frm_seq stable; no bpkt_rq until the handshake completes.
- Run 130 frames with prompt acks -> seq wraps 127->0, win_full never asserted, frm_seq sequence continuous modulo 128.

Source files
------------

// File: rtl/spio_hss_multiplexer_frame_sched_pkg.sv
// Shared constants for the HSS multiplexer frame scheduler.
//   NUM_CH   : number of per-channel packet stores served
//   SEQ_BITS : frame sequence number width (common-header field)
//   WIN      : maximum number of unacked frames in flight
//   fsm_state_e : scheduler FSM encoding
package spio_hss_multiplexer_frame_sched_pkg;

  localparam int NUM_CH   = 8;
  localparam int SEQ_BITS = 7;
  localparam int WIN      = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    COLLECT = 2'd2,
    ISSUE   = 2'd3
  } fsm_state_e;

endpackage

// File: rtl/spio_hss_multiplexer_seq_window.sv
// Sequence/window bookkeeping for the frame scheduler.
// Holds the next sequence to allocate (seq) and the oldest unacked
// sequence (ack_base).
//   clk, rst      : clock, async active-high reset
//   vld_ack       : ack valid, ack_base <= ack_seq
//   vld_nak       : nack valid, ack_base <= ack_seq and seq <= ack_seq
//   ack_seq       : sequence carried by ack/nak
//   inc           : a frame was allocated this cycle, seq <= seq + 1
//   seq           : next sequence number to allocate
//   outstanding   : (seq - ack_base) mod 2^SEQ_BITS
//   win_full      : outstanding >= WIN
module spio_hss_multiplexer_seq_window
  import spio_hss_multiplexer_frame_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                vld_ack,
  input  logic                vld_nak,
  input  logic [SEQ_BITS-1:0] ack_seq,
  input  logic                inc,
  output logic [SEQ_BITS-1:0] seq,
  output logic [SEQ_BITS-1:0] outstanding,
  output logic                win_full
);

  localparam logic [SEQ_BITS-1:0] WIN_C = SEQ_BITS'(WIN);

  logic [SEQ_BITS-1:0] seq_q, seq_d;
  logic [SEQ_BITS-1:0] ack_base_q, ack_base_d;

  always_comb begin
    seq_d      = seq_q;
    ack_base_d = ack_base_q;
    if (inc) seq_d = seq_q + 1'b1;
    if (vld_ack || vld_nak) ack_base_d = ack_seq;
    // A nack rewinds allocation and overrides any increment in the same cycle.
    if (vld_nak) seq_d = ack_seq;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q      <= '0;
      ack_base_q <= '0;
    end else begin
      seq_q      <= seq_d;
      ack_base_q <= ack_base_d;
    end
  end

  // Natural-width subtraction gives the modular distance across wrap.
  assign seq         = seq_q;
  assign outstanding = seq_q - ack_base_q;
  assign win_full    = (outstanding >= WIN_C);

endmodule

// File: rtl/spio_hss_multiplexer_frame_sched.sv
// HSS multiplexer frame scheduler.
// Requests one packet from every channel store at once, collects the
// grant mask and hands a frame descriptor to the frame issue stage,
// keeping at most WIN frames unacked.
//   clk, rst             : clock, async active-high reset
//   st_empty             : per-store empty flags
//   bpkt_rq / bpkt_seq   : broadcast request and its sequence number
//   bpkt_gt              : per-store grants, one cycle after bpkt_rq
//   vld_ack / vld_nak    : remote ack / nack, with ack_seq
//   frm_vld / frm_rdy    : descriptor handshake to the frame issue stage
//   frm_mask / frm_seq   : contributing channels and frame sequence
//   win_full             : window full status
//
// state   | meaning
// IDLE    | wait for data in any store, window space and no nack
// REQ     | bpkt_rq asserted to all stores with bpkt_seq
// COLLECT | latch grant mask; allocate seq if any grant
// ISSUE   | hold descriptor until frm_rdy
module spio_hss_multiplexer_frame_sched
  import spio_hss_multiplexer_frame_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   st_empty,
  output logic [NUM_CH-1:0]   bpkt_rq,
  output logic [SEQ_BITS-1:0] bpkt_seq,
  input  logic [NUM_CH-1:0]   bpkt_gt,
  input  logic                vld_ack,
  input  logic                vld_nak,
  input  logic [SEQ_BITS-1:0] ack_seq,
  output logic                frm_vld,
  input  logic                frm_rdy,
  output logic [NUM_CH-1:0]   frm_mask,
  output logic [SEQ_BITS-1:0] frm_seq,
  output logic                win_full
);

  fsm_state_e          state_q, state_d;
  logic                frm_vld_q, frm_vld_d;
  logic [NUM_CH-1:0]   frm_mask_q, frm_mask_d;
  logic [SEQ_BITS-1:0] frm_seq_q, frm_seq_d;
  logic [SEQ_BITS-1:0] seq;
  logic                inc;

  spio_hss_multiplexer_seq_window u_seq_window (
    .clk         (clk),
    .rst         (rst),
    .vld_ack     (vld_ack),
    .vld_nak     (vld_nak),
    .ack_seq     (ack_seq),
    .inc         (inc),
    .seq         (seq),
    .outstanding (),
    .win_full    (win_full)
  );

  always_comb begin
    state_d    = state_q;
    frm_vld_d  = frm_vld_q;
    frm_mask_d = frm_mask_q;
    frm_seq_d  = frm_seq_q;
    inc        = 1'b0;
    case (state_q)
      IDLE: begin
        if (|(~st_empty) && !win_full && !vld_nak) state_d = REQ;
      end
      REQ: begin
        // The stores drop a request that coincides with a nack themselves.
        state_d = vld_nak ? IDLE : COLLECT;
      end
      COLLECT: begin
        if (vld_nak || (bpkt_gt == '0)) begin
          state_d = IDLE;
        end else begin
          frm_vld_d  = 1'b1;
          frm_mask_d = bpkt_gt;
          frm_seq_d  = seq;
          inc        = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // A nack here only moves the counters; the descriptor completes as is.
        if (frm_rdy) begin
          frm_vld_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      frm_vld_q  <= 1'b0;
      frm_mask_q <= '0;
      frm_seq_q  <= '0;
    end else begin
      state_q    <= state_d;
      frm_vld_q  <= frm_vld_d;
      frm_mask_q <= frm_mask_d;
      frm_seq_q  <= frm_seq_d;
    end
  end

  assign bpkt_rq  = {NUM_CH{state_q == REQ}};
  assign bpkt_seq = seq;
  assign frm_vld  = frm_vld_q;
  assign frm_mask = frm_mask_q;
  assign frm_seq  = frm_seq_q;

endmodule

// File: tb/tb_spio_hss_multiplexer_frame_sched.sv
module tb_spio_hss_multiplexer_frame_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] st_empty;
  logic [7:0] bpkt_rq;
  logic [6:0] bpkt_seq;
  logic [7:0] bpkt_gt;
  logic       vld_ack;
  logic       vld_nak;
  logic [6:0] ack_seq;
  logic       frm_vld;
  logic       frm_rdy;
  logic [7:0] frm_mask;
  logic [6:0] frm_seq;
  logic       win_full;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] gt_val;
  logic       rq_seen;
  int         rq_cnt;

  spio_hss_multiplexer_frame_sched dut (
    .clk      (clk),
    .rst      (rst),
    .st_empty (st_empty),
    .bpkt_rq  (bpkt_rq),
    .bpkt_seq (bpkt_seq),
    .bpkt_gt  (bpkt_gt),
    .vld_ack  (vld_ack),
    .vld_nak  (vld_nak),
    .ack_seq  (ack_seq),
    .frm_vld  (frm_vld),
    .frm_rdy  (frm_rdy),
    .frm_mask (frm_mask),
    .frm_seq  (frm_seq),
    .win_full (win_full)
  );

  always #5 clk = ~clk;

  // Store model: note a request mid-cycle, grant gt_val in the next cycle.
  initial begin
    rq_seen = 1'b0;
    rq_cnt  = 0;
    bpkt_gt = 8'h00;
    forever begin
      @(negedge clk);
      rq_seen = (bpkt_rq != 8'h00);
      if (rq_seen) rq_cnt++;
      @(posedge clk);
      #1;
      bpkt_gt = rq_seen ? gt_val : 8'h00;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    st_empty = 8'hFF;
    frm_rdy  = 1'b0;
    vld_ack  = 1'b0;
    vld_nak  = 1'b0;
    ack_seq  = 7'd0;
    gt_val   = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    tick();
    rq_cnt = 0;
  endtask

  task automatic test_reset();
    bit found;
    do_reset();
    st_empty = 8'h00;
    gt_val   = 8'h3C;
    found    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (frm_vld === 1'b1) begin found = 1'b1; break; end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL reset_prep_vld: frm_vld not seen within 10 cycles"); end
    // Async reset between clock edges.
    #1;
    rst = 1'b1;
    #1;
    vectors++;
    if (bpkt_rq !== 8'h00) begin miscompares++; $display("FAIL reset_bpkt_rq: got %h want 00", bpkt_rq); end
    vectors++;
    if (bpkt_seq !== 7'd0) begin miscompares++; $display("FAIL reset_bpkt_seq: got %0d want 0", bpkt_seq); end
    vectors++;
    if (frm_vld !== 1'b0) begin miscompares++; $display("FAIL reset_frm_vld: got %b want 0", frm_vld); end
    vectors++;
    if (frm_mask !== 8'h00) begin miscompares++; $display("FAIL reset_frm_mask: got %h want 00", frm_mask); end
    vectors++;
    if (frm_seq !== 7'd0) begin miscompares++; $display("FAIL reset_frm_seq: got %0d want 0", frm_seq); end
    vectors++;
    if (win_full !== 1'b0) begin miscompares++; $display("FAIL reset_win_full: got %b want 0", win_full); end
    do_reset();
  endtask

  task automatic test_single_frame();
    do_reset();
    st_empty = 8'hF7;
    gt_val   = 8'h08;
    frm_rdy  = 1'b1;
    tick();
    vectors++;
    if (bpkt_rq !== 8'hFF) begin miscompares++; $display("FAIL single_req_rq: got %h want FF", bpkt_rq); end
    vectors++;
    if (bpkt_seq !== 7'd0) begin miscompares++; $display("FAIL single_req_seq: got %0d want 0", bpkt_seq); end
    tick();
    vectors++;
    if (bpkt_rq !== 8'h00) begin miscompares++; $display("FAIL single_collect_rq: got %h want 00", bpkt_rq); end
    vectors++;
    if (frm_vld !== 1'b0) begin miscompares++; $display("FAIL single_collect_vld: got %b want 0", frm_vld); end
    tick();
    vectors++;
    if (frm_vld !== 1'b1) begin miscompares++; $display("FAIL single_issue_vld: got %b want 1", frm_vld); end
    vectors++;
    if (frm_mask !== 8'h08) begin miscompares++; $display("FAIL single_issue_mask: got %h want 08", frm_mask); end
    vectors++;
    if (frm_seq !== 7'd0) begin miscompares++; $display("FAIL single_issue_seq: got %0d want 0", frm_seq); end
    tick();
    vectors++;
    if (frm_vld !== 1'b0) begin miscompares++; $display("FAIL single_idle_vld: got %b want 0", frm_vld); end
    tick();
    vectors++;
    if (bpkt_rq !== 8'hFF) begin miscompares++; $display("FAIL single_period_rq: got %h want FF", bpkt_rq); end
    vectors++;
    if (bpkt_seq !== 7'd1) begin miscompares++; $display("FAIL single_period_seq: got %0d want 1", bpkt_seq); end
    st_empty = 8'hFF;
    repeat (4) tick();
  endtask

  task automatic test_no_grant();
    int vld_cnt;
    int bad_seq;
    do_reset();
    st_empty = 8'h00;
    gt_val   = 8'h00;
    frm_rdy  = 1'b1;
    vld_cnt  = 0;
    bad_seq  = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (frm_vld !== 1'b0) vld_cnt++;
      if (bpkt_rq != 8'h00 && bpkt_seq !== 7'd0) bad_seq++;
    end
    vectors++;
    if (vld_cnt != 0) begin miscompares++; $display("FAIL nogrant_vld: frm_vld seen %0d cycles want 0", vld_cnt); end
    vectors++;
    if (bad_seq != 0) begin miscompares++; $display("FAIL nogrant_seq: %0d requests with seq != 0 want 0", bad_seq); end
    vectors++;
    if (rq_cnt < 3) begin miscompares++; $display("FAIL nogrant_retry: got %0d requests want at least 3", rq_cnt); end
    st_empty = 8'hFF;
    repeat (3) tick();
  endtask

  task automatic test_window();
    int  hs;
    bit  found;
    do_reset();
    st_empty = 8'h00;
    gt_val   = 8'hFF;
    frm_rdy  = 1'b1;
    hs       = 0;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (frm_vld === 1'b1) hs++;
    end
    vectors++;
    if (hs != 8) begin miscompares++; $display("FAIL window_frames: got %0d frames want 8", hs); end
    vectors++;
    if (rq_cnt != 8) begin miscompares++; $display("FAIL window_requests: got %0d requests want 8", rq_cnt); end
    vectors++;
    if (win_full !== 1'b1) begin miscompares++; $display("FAIL window_full: got %b want 1", win_full); end
    ack_seq = 7'd3;
    vld_ack = 1'b1;
    tick();
    vld_ack = 1'b0;
    vectors++;
    if (win_full !== 1'b0) begin miscompares++; $display("FAIL window_after_ack: got %b want 0", win_full); end
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bpkt_rq != 8'h00) begin found = 1'b1; break; end
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL window_resume: no request within 10 cycles after ack");
    end else if (bpkt_seq !== 7'd8) begin
      miscompares++; $display("FAIL window_resume_seq: got %0d want 8", bpkt_seq);
    end
    st_empty = 8'hFF;
    repeat (4) tick();
  endtask

  task automatic test_nak_collect();
    int hs;
    int vld_cnt;
    bit found;
    do_reset();
    st_empty = 8'h00;
    gt_val   = 8'hFF;
    frm_rdy  = 1'b1;
    hs       = 0;
    for (int k = 0; k < 60 && hs < 6; k++) begin
      tick();
      if (frm_vld === 1'b1) hs++;
    end
    vectors++;
    if (hs != 6) begin miscompares++; $display("FAIL nak_prefill: got %0d frames want 6", hs); end
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bpkt_rq != 8'h00) begin found = 1'b1; break; end
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL nak_req: no request within 10 cycles");
    end else if (bpkt_seq !== 7'd6) begin
      miscompares++; $display("FAIL nak_req_seq: got %0d want 6", bpkt_seq);
    end
    tick();
    vld_nak = 1'b1;
    ack_seq = 7'd2;
    tick();
    vld_nak = 1'b0;
    vectors++;
    if (frm_vld !== 1'b0) begin miscompares++; $display("FAIL nak_discard: frm_vld got %b want 0", frm_vld); end
    vectors++;
    if (win_full !== 1'b0) begin miscompares++; $display("FAIL nak_win: win_full got %b want 0", win_full); end
    found   = 1'b0;
    vld_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (frm_vld !== 1'b0) vld_cnt++;
      if (bpkt_rq != 8'h00) begin found = 1'b1; break; end
    end
    vectors++;
    if (vld_cnt != 0) begin miscompares++; $display("FAIL nak_no_frame: frm_vld seen %0d cycles want 0", vld_cnt); end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL nak_resume: no request within 10 cycles");
    end else if (bpkt_seq !== 7'd2) begin
      miscompares++; $display("FAIL nak_resume_seq: got %0d want 2", bpkt_seq);
    end
    st_empty = 8'hFF;
    repeat (4) tick();
  endtask

  task automatic test_stall();
    bit found;
    int rq0;
    do_reset();
    st_empty = 8'h00;
    gt_val   = 8'h5A;
    frm_rdy  = 1'b0;
    found    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (frm_vld === 1'b1) begin found = 1'b1; break; end
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL stall_vld: frm_vld not seen within 10 cycles"); end
    rq0 = rq_cnt;
    for (int k = 0; k < 10; k++) begin
      tick();
      vectors++;
      if (frm_vld !== 1'b1) begin miscompares++; $display("FAIL stall_hold_vld: cycle %0d got %b want 1", k, frm_vld); end
      vectors++;
      if (frm_mask !== 8'h5A) begin miscompares++; $display("FAIL stall_hold_mask: cycle %0d got %h want 5A", k, frm_mask); end
      vectors++;
      if (frm_seq !== 7'd0) begin miscompares++; $display("FAIL stall_hold_seq: cycle %0d got %0d want 0", k, frm_seq); end
    end
    vectors++;
    if (rq_cnt != rq0) begin miscompares++; $display("FAIL stall_no_req: got %0d requests want %0d", rq_cnt, rq0); end
    frm_rdy = 1'b1;
    tick();
    vectors++;
    if (frm_vld !== 1'b0) begin miscompares++; $display("FAIL stall_release: frm_vld got %b want 0", frm_vld); end
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bpkt_rq != 8'h00) begin found = 1'b1; break; end
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL stall_resume: no request within 10 cycles");
    end else if (bpkt_seq !== 7'd1) begin
      miscompares++; $display("FAIL stall_resume_seq: got %0d want 1", bpkt_seq);
    end
    st_empty = 8'hFF;
    repeat (4) tick();
  endtask

  task automatic test_wrap();
    logic [6:0] exp;
    int         wf_cnt;
    bit         found;
    do_reset();
    st_empty = 8'h00;
    gt_val   = 8'hFF;
    frm_rdy  = 1'b1;
    exp      = 7'd0;
    wf_cnt   = 0;
    for (int i = 0; i < 130; i++) begin
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
        if (win_full !== 1'b0) wf_cnt++;
        if (frm_vld === 1'b1) begin found = 1'b1; break; end
        tick();
      end
      vectors++;
      if (!found) begin
        miscompares++; $display("FAIL wrap_timeout: frame %0d not seen within 10 cycles", i);
        break;
      end else if (frm_seq !== exp) begin
        miscompares++; $display("FAIL wrap_seq: frame %0d got %0d want %0d", i, frm_seq, exp);
      end
      exp     = exp + 7'd1;
      ack_seq = exp;
      vld_ack = 1'b1;
      tick();
      vld_ack = 1'b0;
    end
    vectors++;
    if (wf_cnt != 0) begin miscompares++; $display("FAIL wrap_win_full: asserted %0d cycles want 0", wf_cnt); end
    st_empty = 8'hFF;
    repeat (4) tick();
  endtask

  initial begin
    rst      = 1'b1;
    st_empty = 8'hFF;
    frm_rdy  = 1'b0;
    vld_ack  = 1'b0;
    vld_nak  = 1'b0;
    ack_seq  = 7'd0;
    gt_val   = 8'h00;
    test_reset();
    test_single_frame();
    test_no_grant();
    test_window();
    test_nak_collect();
    test_stall();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
